mx_int8_negate_seq: RTL
=======================

// Module: mx_int8_negate_seq
// PURPOSE
//  Consumer end of the MXINT8 block-transfer interface: samples a full block (BLOCK_SIZE INT8
//  elements plus shared E8M0 scale) on a one-cycle data_ready_i pulse. Negates the block
//  serially, one element per cycle, with saturation. Presents the result with a one-cycle
//  block_valid_o pulse. Sits between the MXINT8 block source and the MX ALU writeback/compare stage.
// PARAMETERS
//  BLOCK_SIZE   32  elements per MX block (`BLOCK_SIZE); power of two, >= 2
//  ELEM_WIDTH   8   element width (`MXINT8_ELEMENT_WIDTH), two's complement
//  SCALE_WIDTH  8   shared E8M0 scale width
// PORTS
//  clk            in   1                       clock, all logic on posedge
//  rst            in   1                       synchronous, active-high reset
//  data_ready_i   in   1                       one-cycle pulse: elements_i/scale_i valid this cycle
//  elements_i     in   ELEM_WIDTH x BLOCK_SIZE unpacked [0:BLOCK_SIZE-1] input block
//  scale_i        in   SCALE_WIDTH             shared scale of input block
//  busy_o         out  1                       high in RUN
//  elements_o     out  ELEM_WIDTH x BLOCK_SIZE negated block, held between updates
//  scale_o        out  SCALE_WIDTH             scale of result block (= captured scale_i, unchanged)
//  block_valid_o  out  1                       one-cycle pulse: elements_o/scale_o/sat_count_o valid
//  sat_count_o    out  $clog2(BLOCK_SIZE+1)    number of saturated elements in result block
//  overrun_o      out  1                       one-cycle pulse: data_ready_i dropped while busy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, idx=0, all outputs and buffers = 0. This includes
//    elements_o, scale_o, sat_count_o, block_valid_o, overrun_o and busy_o.
//    Reset mid-block discards the in-flight block: no block_valid_o, elements_o cleared.
//  - FSM IDLE/RUN/DONE:
//    IDLE: data_ready_i=1 -> capture elements_i, scale_i into in_buf; idx=0, sat_acc=0 -> RUN.
//    RUN:  each edge: work_buf[idx] = satneg(in_buf[idx]), sat_acc += (in_buf[idx]==-128).
//          Then idx++. At idx==BLOCK_SIZE-1: copy work_buf (incl. last element) to elements_o.
//          Also load scale_o and sat_count_o, then go to DONE.
//    DONE: block_valid_o=1 for exactly this cycle. Then:
//          data_ready_i=1 -> capture a new block, go to RUN.
//          data_ready_i=0 -> go to IDLE.
//  - Latency: data_ready_i sampled at edge N -> block_valid_o high in the cycle after edge
//    N+BLOCK_SIZE. Back-to-back pulses spaced BLOCK_SIZE+1 cycles apart are all accepted.
//  - satneg(x): x==-128 (8'h80) -> +127 (8'h7F); x==0 -> 0; else -x. Width is never widened.
//  - elements_o/scale_o/sat_count_o update atomically only on entry to DONE. They are stable
//    during the next block's RUN.
//  - data_ready_i while in RUN: pulse ignored, in_buf not disturbed.
//    overrun_o=1 in the following cycle; the current block completes normally.
//  - rst has priority over every other event in the same cycle.
//  - busy_o is registered: it is 1 exactly in the cycles the FSM is in RUN.
// STRUCTURE
//  - Shared mxint8 package/include holds:
//    BLOCK_SIZE, ELEM_WIDTH, SCALE_WIDTH constants;
//    INT8_MAX=8'sd127, INT8_MIN=-8'sd128;
//    the element typedef and the state enum {IDLE, RUN, DONE}.
//  - Sub-module mx_int8_sat_neg: combinational single-element saturating negate with sat flag.
//    One instance, muxed by idx.
//  - Top holds the FSM, idx counter ($clog2(BLOCK_SIZE) bits), in_buf, work_buf, sat_acc
//    and the output registers.
// TESTING
//  1 Reset: hold rst 2 cycles -> all outputs 0, busy_o=0.
//    Pulse data_ready_i immediately after -> accepted.
//  2 Block of all 8'h05, scale 8'h7F -> block_valid_o exactly BLOCK_SIZE+1 cycles after the
//    pulse. Result: all 8'hFB, scale_o=8'h7F, sat_count_o=0.
//  3 Element[3]=8'h80, element[7]=8'h00, others 8'h81 -> [3]=8'h7F, [7]=8'h00,
//    others 8'h7F, sat_count_o=1.
//  4 Ten blocks with random data, pulses spaced BLOCK_SIZE+1 cycles, then three blocks
//    each with one random zero element -> 13 block_valid_o pulses.
//    Each result equals the scoreboard satneg result; the zero index still reads 0.
//  5 Second data_ready_i 5 cycles into RUN -> overrun_o pulses once.
//    The first block's result is unchanged; the second block is never produced.
//  6 rst asserted at idx=10 -> no block_valid_o, elements_o=0, next pulse processes normally.

Source files
------------

// File: rtl/mx_int8_pkg.sv
// Shared MXINT8 constants, element type and FSM state encoding.
// Imported by the serial saturating-negate block and its sub-module.
package mx_int8_pkg;

   localparam int BLOCK_SIZE  = 32;
   localparam int ELEM_WIDTH  = 8;
   localparam int SCALE_WIDTH = 8;

   localparam int IDX_W = $clog2(BLOCK_SIZE);
   localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

   localparam logic signed [ELEM_WIDTH-1:0] INT8_MAX = 8'sd127;
   localparam logic signed [ELEM_WIDTH-1:0] INT8_MIN = -8'sd128;

   typedef logic [ELEM_WIDTH-1:0] elem_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mx_int8_sat_neg.sv
// Combinational single-element saturating negate.
// Ports: x_i element in, y_o negated element, sat_o high when x_i was INT8_MIN.
module mx_int8_sat_neg
   import mx_int8_pkg::*;
(
   input  elem_t x_i,
   output elem_t y_o,
   output logic  sat_o
);

   always_comb begin
      sat_o = (x_i == elem_t'(INT8_MIN));
      // -128 has no positive counterpart; clamp instead of wrapping
      y_o   = sat_o ? elem_t'(INT8_MAX) : elem_t'(-x_i);
   end

endmodule

// File: rtl/mx_int8_negate_seq.sv
// MXINT8 block consumer: captures a block, negates it one element per cycle
// with saturation, then presents the result with a one-cycle valid pulse.
// Ports: data_ready_i/elements_i/scale_i in; busy_o, elements_o, scale_o,
// block_valid_o, sat_count_o, overrun_o out. Sync active-high rst.
module mx_int8_negate_seq
   import mx_int8_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_ready_i,
   input  logic [ELEM_WIDTH-1:0]  elements_i [BLOCK_SIZE],
   input  logic [SCALE_WIDTH-1:0] scale_i,
   output logic                   busy_o,
   output logic [ELEM_WIDTH-1:0]  elements_o [BLOCK_SIZE],
   output logic [SCALE_WIDTH-1:0] scale_o,
   output logic                   block_valid_o,
   output logic [CNT_W-1:0]       sat_count_o,
   output logic                   overrun_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       sat_acc_q, sat_acc_d;
   elem_t                  in_buf_q   [BLOCK_SIZE];
   elem_t                  work_buf_q [BLOCK_SIZE];
   logic [SCALE_WIDTH-1:0] scale_buf_q;

   elem_t                  elems_q [BLOCK_SIZE];
   logic [SCALE_WIDTH-1:0] scale_q;
   logic [CNT_W-1:0]       sat_cnt_q;
   logic                   busy_q;
   logic                   valid_q;
   logic                   ovr_q;

   elem_t cur_elem;
   elem_t neg_elem;
   logic  neg_sat;
   logic  capture;
   logic  last;

   assign cur_elem = in_buf_q[idx_q];

   mx_int8_sat_neg u_sat_neg (
      .x_i   (cur_elem),
      .y_o   (neg_elem),
      .sat_o (neg_sat)
   );

   // A new block is only accepted when not mid-block
   assign capture = data_ready_i &&
                    ((state_q == IDLE) || (state_q == DONE));
   assign last    = (state_q == RUN) && (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (data_ready_i) state_d = RUN;
         end
         RUN: begin
            idx_d = idx_q + 1'b1;
            if (last) begin
               state_d = DONE;
               idx_d   = '0;
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = data_ready_i ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      sat_acc_d = sat_acc_q;
      if (capture)
         sat_acc_d = '0;
      else if (state_q == RUN)
         sat_acc_d = sat_acc_q + CNT_W'(neg_sat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sat_acc_q   <= '0;
         scale_buf_q <= '0;
         scale_q     <= '0;
         sat_cnt_q   <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            in_buf_q[i]   <= '0;
            work_buf_q[i] <= '0;
            elems_q[i]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sat_acc_q <= sat_acc_d;
         busy_q    <= (state_d == RUN);
         valid_q   <= last;
         ovr_q     <= data_ready_i && (state_q == RUN);
         if (capture) begin
            scale_buf_q <= scale_i;
            for (int i = 0; i < BLOCK_SIZE; i++)
               in_buf_q[i] <= elements_i[i];
         end
         if (state_q == RUN)
            work_buf_q[idx_q] <= neg_elem;
         // Last element bypasses work_buf so the whole block lands at once
         if (last) begin
            scale_q   <= scale_buf_q;
            sat_cnt_q <= sat_acc_d;
            for (int i = 0; i < BLOCK_SIZE; i++)
               elems_q[i] <= (IDX_W'(i) == idx_q) ? neg_elem
                                                  : work_buf_q[i];
         end
      end
   end

   assign busy_o        = busy_q;
   assign elements_o    = elems_q;
   assign scale_o       = scale_q;
   assign block_valid_o = valid_q;
   assign sat_count_o   = sat_cnt_q;
   assign overrun_o     = ovr_q;

endmodule
